// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of an async FIFO, in the read clock domain.
// It pops words from the FIFO's rempty/rinc/rdata interface into a two-entry
// output buffer and presents them as a valid/ready stream. Every BURST_LEN-th
// transferred word is tagged with m_last.
//
// Ports:
//   rclk     read-domain clock
//   rrst     asynchronous active-high reset
//   rempty   FIFO empty flag; when low, rdata holds a valid word
//   rdata    FIFO read data at the current read address
//   rinc     pop strobe to the FIFO (pointer advances on the rclk edge)
//   m_valid  output word valid
//   m_ready  downstream accepts the word
//   m_data   output word (head of the buffer)
//   m_last   current word is the final word of a burst
module fifo_rd_stream #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last
);

    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e             state_q, state_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic [DSIZE-1:0] tail_q, tail_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             pop;
    logic             xfer;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        beat_d  = beat_q;

        // Pop decision uses only registered occupancy and rempty, so m_ready
        // never reaches rinc combinationally.
        rinc    = !rempty && (state_q != TWO) && !rrst;
        m_valid = (state_q != EMPTY);
        m_data  = head_q;
        m_last  = m_valid && (beat_q == BEAT_LAST);
        pop     = rinc;
        xfer    = m_valid && m_ready;

        case (state_q)
            EMPTY: begin
                if (pop) begin
                    head_d  = rdata;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (pop && xfer) begin
                    // Outgoing head is replaced in the same edge: no bubble.
                    head_d = rdata;
                end else if (pop) begin
                    tail_d  = rdata;
                    state_d = TWO;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (xfer) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (xfer) begin
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
        end
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer of the async FIFO, clocked in the read clock domain.
- Drains the FIFO's rempty/rinc/rdata interface and presents the words as a valid/ready stream.
- Uses a 2-entry output buffer so the downstream path sustains one word per cycle.
- Tags every BURST_LEN-th transferred word with m_last for packet-oriented consumers.
- There is no combinational path from m_ready to rinc.

Parameters:
- DSIZE, 8, data word width; must match the FIFO DSIZE.
- BURST_LEN, 4, words per burst for m_last generation; must be >= 1.

Ports:
- rclk  input  1  read-domain clock.
- rrst  input  1  asynchronous active-high reset.
- rempty  input  1  FIFO empty flag; when low, rdata holds a valid word in the same cycle.
- rdata  input  DSIZE  FIFO read data at the current read address; combinational from the FIFO memory.
- rinc  output  1  pop strobe to the FIFO; the FIFO advances its read pointer on the rclk edge.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DSIZE  output word.
- m_last  output  1  current word is the final word of a burst.

Behaviour:
- Reset (async assert, deasserted synchronously by the system): cnt=0, head=0, tail=0, beat_cnt=0; m_valid=0, m_last=0, m_data=0.
- rinc is forced to 0 while rrst is high.
- Occupancy register cnt takes states EMPTY(0), ONE(1), TWO(2). The head register drives m_data; the tail register holds the second word.
- Signals: pop = rinc; xfer = m_valid & m_ready.
- rinc = !rempty & (cnt != 2) & !rrst. It depends only on registered state and rempty.
- m_valid = (cnt != 0); m_data = head.
- Transitions:
  - EMPTY: if pop, head<=rdata, go to ONE.
  - ONE, pop & xfer: head<=rdata, stay in ONE. This is the steady-state full-throughput case.
  - ONE, pop only: tail<=rdata, go to TWO.
  - ONE, xfer only: go to EMPTY.
  - ONE, neither: hold.
  - TWO: no pop. On xfer, head<=tail and go to ONE. Otherwise hold.
- Ordering: words leave in exactly FIFO pop order. No word is duplicated or dropped.
- While m_valid=1 and m_ready=0, m_data and m_last stay stable.
- Latency: a word present at the FIFO (rempty=0) while the buffer is EMPTY appears on m_valid/m_data on the next rclk edge.
- Throughput:
  - With m_ready held at 1 and the FIFO non-empty, one word transfers per cycle.
  - Leaving TWO costs one bubble-free cycle from the held tail word.
- beat_cnt: width $clog2(BURST_LEN) (minimum 1 bit). It increments on xfer and wraps from BURST_LEN-1 to 0.
- m_last = m_valid & (beat_cnt == BURST_LEN-1). With BURST_LEN=1, m_last = m_valid.
- Boundary conditions:
  - rempty=1: no pop; the buffer drains normally.
  - rempty deasserting while cnt==2: no pop until an xfer frees a slot.
  - Reset mid-burst: buffered words are discarded and beat_cnt returns to 0. The FIFO pointers are reset by the same domain reset, so the system stays consistent.
  - Simultaneous pop and xfer in ONE: the new word replaces head in the same edge; there is no bubble.

Test Plan:
- Reset, then rempty=1, m_ready=1 for 10 cycles -> rinc=0, m_valid=0, m_last=0, m_data=0 throughout.
- FIFO preloaded with 0x10..0x17, m_ready=1 -> rinc high for 8 consecutive cycles; m_data shows 0x10..0x17 on consecutive cycles starting 1 cycle after the first pop; m_last high on 0x13 and 0x17 only.
- Same preload, m_ready=0 -> exactly 2 pops (cnt=2), rinc then 0, m_data holds 0x10. Release m_ready -> 0x10, 0x11, 0x12... follow with no loss or duplication.
- Random m_ready (50%) over 200 words of incrementing data -> the scoreboard sees an exact in-order sequence; m_data/m_last stable whenever m_valid & !m_ready; m_last exactly every 4th transferred word.
- Assert rrst for 1 cycle after 2 of 4 burst words transfer -> outputs zero immediately (async); after release, the next transferred word has beat_cnt=0 and m_last first appears on the 4th post-reset word.
- BURST_LEN=1 build, 5 words -> m_last=1 on every valid word.
